// File: rtl/sram_access_sequencer.sv
// Timing sequencer for the 64x64 SRAM macro: orders precharge, wordline,
// write-driver and sense-amp enables for one access at a time, all registered.
module sram_access_sequencer #(
    parameter int ROW_BITS     = 6,
    parameter int COL_BITS     = 6,
    parameter int PRE_CYCLES   = 2,
    parameter int WL_CYCLES    = 2,
    parameter int SENSE_CYCLES = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req,
    input  logic                         we,
    input  logic [ROW_BITS+COL_BITS-1:0] addr,
    input  logic                         wdata,
    output logic                         ready,
    output logic [ROW_BITS-1:0]          row_addr,
    output logic [COL_BITS-1:0]          col_addr,
    output logic                         wdata_q,
    output logic                         precharge_en,
    output logic                         wl_en,
    output logic                         wr_en,
    output logic                         sense_en,
    input  logic                         sa_out,
    output logic                         rdata,
    output logic                         rvalid,
    output logic                         done
);

    localparam int MAX_PW  = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
    localparam int MAX_CYC = (MAX_PW > SENSE_CYCLES) ? MAX_PW : SENSE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] PRE_LOAD   = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WL_LOAD    = CNT_W'(WL_CYCLES - 1);
    localparam logic [CNT_W-1:0] SENSE_LOAD = CNT_W'(SENSE_CYCLES - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PRE     = 3'd1;
    localparam logic [2:0] ST_ACT     = 3'd2;
    localparam logic [2:0] ST_SENSE   = 3'd3;
    localparam logic [2:0] ST_RECOVER = 3'd4;

    logic [2:0]       state_r;
    logic [2:0]       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             we_r;
    logic             accept_s;
    logic             capture_s;

    // Next-state and shared dwell counter; each state reloads the counter for its successor.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        accept_s  = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    state_s  = ST_PRE;
                    cnt_s    = PRE_LOAD;
                    accept_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_ACT;
                    cnt_s   = WL_LOAD;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_ACT: begin
                if (cnt_r == CNT_ZERO) begin
                    if (we_r) begin
                        state_s = ST_RECOVER;
                    end else begin
                        state_s = ST_SENSE;
                        cnt_s   = SENSE_LOAD;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_SENSE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s   = ST_RECOVER;
                    capture_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_RECOVER: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and request latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            we_r     <= 1'b0;
            row_addr <= '0;
            col_addr <= '0;
            wdata_q  <= 1'b0;
            rdata    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (accept_s) begin
                we_r     <= we;
                row_addr <= addr[ROW_BITS+COL_BITS-1:COL_BITS];
                col_addr <= addr[COL_BITS-1:0];
                wdata_q  <= wdata;
            end
            if (capture_s) begin
                rdata <= sa_out;
            end
        end
    end

    // Array controls decoded from the next state so the flops themselves drive the analog nets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready        <= 1'b1;
            precharge_en <= 1'b1;
            wl_en        <= 1'b0;
            wr_en        <= 1'b0;
            sense_en     <= 1'b0;
            rvalid       <= 1'b0;
            done         <= 1'b0;
        end else begin
            ready        <= (state_s == ST_IDLE);
            precharge_en <= (state_s == ST_IDLE) || (state_s == ST_PRE) || (state_s == ST_RECOVER);
            wl_en        <= (state_s == ST_ACT) || (state_s == ST_SENSE);
            wr_en        <= (state_s == ST_ACT) && we_r;
            sense_en     <= (state_s == ST_SENSE);
            rvalid       <= (state_s == ST_RECOVER) && !we_r;
            done         <= (state_s == ST_RECOVER);
        end
    end

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Bench for sram_access_sequencer: default and non-default timing instances
// checked cycle by cycle against an access-window model plus invariants.
module tb_sram_access_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic        req[2], we[2], wdata[2], sa_out[2];
    logic [11:0] addr[2];
    logic        ready[2], precharge_en[2], wl_en[2], wr_en[2], sense_en[2];
    logic        rdata[2], rvalid[2], done[2], wdata_q[2];
    logic [5:0]  row_addr[2], col_addr[2];

    int pre_c[2] = '{2, 1};
    int wl_c[2]  = '{2, 3};
    int se_c[2]  = '{1, 2};

    logic [11:0] m_addr[2];
    logic        m_wdata[2];
    logic        m_rdata[2];

    sram_access_sequencer dut_a (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we[0]), .addr(addr[0]),
        .wdata(wdata[0]), .ready(ready[0]), .row_addr(row_addr[0]),
        .col_addr(col_addr[0]), .wdata_q(wdata_q[0]), .precharge_en(precharge_en[0]),
        .wl_en(wl_en[0]), .wr_en(wr_en[0]), .sense_en(sense_en[0]),
        .sa_out(sa_out[0]), .rdata(rdata[0]), .rvalid(rvalid[0]), .done(done[0])
    );

    sram_access_sequencer #(
        .PRE_CYCLES(1), .WL_CYCLES(3), .SENSE_CYCLES(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we[1]), .addr(addr[1]),
        .wdata(wdata[1]), .ready(ready[1]), .row_addr(row_addr[1]),
        .col_addr(col_addr[1]), .wdata_q(wdata_q[1]), .precharge_en(precharge_en[1]),
        .wl_en(wl_en[1]), .wr_en(wr_en[1]), .sense_en(sense_en[1]),
        .sa_out(sa_out[1]), .rdata(rdata[1]), .rvalid(rvalid[1]), .done(done[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_latched(input int i, input string pfx);
        chk({pfx, " row"}, 32'(row_addr[i]), 32'(m_addr[i][11:6]));
        chk({pfx, " col"}, 32'(col_addr[i]), 32'(m_addr[i][5:0]));
        chk({pfx, " wdq"}, 32'(wdata_q[i]), 32'(m_wdata[i]));
        chk({pfx, " rdata"}, 32'(rdata[i]), 32'(m_rdata[i]));
    endtask

    task automatic check_idle(input int i);
        string p;
        p = $sformatf("d%0d idle", i);
        chk({p, " ready"}, 32'(ready[i]), 32'd1);
        chk({p, " pre"}, 32'(precharge_en[i]), 32'd1);
        chk({p, " wl"}, 32'(wl_en[i]), 32'd0);
        chk({p, " wr"}, 32'(wr_en[i]), 32'd0);
        chk({p, " sense"}, 32'(sense_en[i]), 32'd0);
        chk({p, " done"}, 32'(done[i]), 32'd0);
        chk({p, " rvalid"}, 32'(rvalid[i]), 32'd0);
        check_latched(i, p);
    endtask

    // One complete access; entered and left at a negedge where the instance is idle.
    task automatic do_access(input int i, input logic w, input logic [11:0] a,
                             input logic d, input logic sbit);
        int  p, l, s, last;
        bit  rd;
        string tg;
        p    = pre_c[i];
        l    = wl_c[i];
        s    = se_c[i];
        rd   = !w;
        last = p + l + (rd ? s : 0) + 1;
        check_idle(i);
        req[i]    = 1'b1;
        we[i]     = w;
        addr[i]   = a;
        wdata[i]  = d;
        sa_out[i] = ~sbit;
        m_addr[i]  = a;
        m_wdata[i] = d;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (rd && k == last) m_rdata[i] = sbit;
            tg = $sformatf("d%0d %s k%0d", i, rd ? "rd" : "wr", k);
            chk({tg, " ready"}, 32'(ready[i]), 32'd0);
            chk({tg, " pre"}, 32'(precharge_en[i]), 32'(k <= p || k == last));
            chk({tg, " wl"}, 32'(wl_en[i]), 32'(k > p && k < last));
            chk({tg, " wr"}, 32'(wr_en[i]), 32'(w && k > p && k <= p + l));
            chk({tg, " sense"}, 32'(sense_en[i]), 32'(rd && k > p + l && k < last));
            chk({tg, " done"}, 32'(done[i]), 32'(k == last));
            chk({tg, " rvalid"}, 32'(rvalid[i]), 32'(rd && k == last));
            check_latched(i, tg);
            // Busy-time noise on every request input; the sequencer must ignore it.
            req[i]    = 1'($urandom_range(0, 1));
            we[i]     = 1'($urandom_range(0, 1));
            addr[i]   = 12'($urandom);
            wdata[i]  = 1'($urandom_range(0, 1));
            sa_out[i] = (rd && k > p + l && k <= p + l + s) ? sbit : ~sbit;
        end
        @(negedge clk);
        req[i] = 1'b0;
    endtask

    task automatic idle(input int i, input int n);
        req[i] = 1'b0;
        for (int k = 0; k < n; k++) begin
            check_idle(i);
            @(negedge clk);
        end
    endtask

    // Safety invariants on both instances every cycle.
    always @(negedge clk) begin
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("d%0d inv wl&pre", j), 32'(wl_en[j] & precharge_en[j]), 32'd0);
            chk($sformatf("d%0d inv wr->wl", j), 32'(wr_en[j] & ~wl_en[j]), 32'd0);
            chk($sformatf("d%0d inv wr&sense", j), 32'(wr_en[j] & sense_en[j]), 32'd0);
            chk($sformatf("d%0d inv rvalid->done", j), 32'(rvalid[j] & ~done[j]), 32'd0);
            chk($sformatf("d%0d inv ready&busy", j),
                32'(ready[j] & (wl_en[j] | done[j])), 32'd0);
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; wdata[i] = 1'b0; sa_out[i] = 1'b0; addr[i] = 12'h000;
            m_addr[i] = 12'h000; m_wdata[i] = 1'b0; m_rdata[i] = 1'b0;
        end
        @(negedge clk);
        check_idle(0);
        check_idle(1);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle(0);

        // Reset in the middle of a write's wordline phase.
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 12'h5A5; wdata[0] = 1'b1;
        @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst pre-check wl", 32'(wl_en[0]), 32'd1);
        chk("rst pre-check wr", 32'(wr_en[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst wl", 32'(wl_en[0]), 32'd0);
        chk("rst wr", 32'(wr_en[0]), 32'd0);
        chk("rst pre", 32'(precharge_en[0]), 32'd1);
        chk("rst done", 32'(done[0]), 32'd0);
        chk("rst rvalid", 32'(rvalid[0]), 32'd0);
        chk("rst row", 32'(row_addr[0]), 32'd0);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle(0);
        check_idle(1);

        // Directed accesses on the default-timing instance.
        do_access(0, 1'b1, 12'hFC1, 1'b1, 1'b0);
        chk("wr row63", 32'(row_addr[0]), 32'd63);
        chk("wr col1", 32'(col_addr[0]), 32'd1);
        idle(0, 2);
        do_access(0, 1'b0, 12'h040, 1'b0, 1'b1);
        chk("rd ready after", 32'(ready[0]), 32'd1);
        chk("rd rdata1", 32'(rdata[0]), 32'd1);
        // Back-to-back: write then read with a single idle cycle between.
        do_access(0, 1'b1, 12'h3C7, 1'b0, 1'b1);
        do_access(0, 1'b0, 12'h812, 1'b1, 1'b0);
        idle(0, 1);

        // Non-default timing instance.
        do_access(1, 1'b0, 12'hABC, 1'b0, 1'b1);
        do_access(1, 1'b1, 12'h123, 1'b1, 1'b0);
        do_access(1, 1'b0, 12'hFFF, 1'b1, 1'b0);
        idle(1, 1);

        // Randomized accesses with random gaps on both instances.
        for (int n = 0; n < 40; n++) begin
            int i;
            i = n % 2;
            do_access(i, 1'($urandom_range(0, 1)), 12'($urandom),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            idle(i, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
